// File: rtl/rx_control.sv
// rx_control: receive-side frame buffer between the MAC receiver and the bridge core.
// Buffers one whole frame, rejects runt/oversize/errored frames and replays good
// frames over a valid/ready byte handshake with a last-byte marker and length.
// Optional feature macro: RX_STATS_EN adds good_cnt_o / drop_cnt_o frame counters.
module rx_control #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 256,
  parameter int ADDR_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_mac_data,
  input  logic        rx_mac_valid,
  input  logic        rx_mac_last,
  input  logic        rx_mac_err,
  output logic [7:0]  rx_data_o,
  output logic        rx_data_valid_o,
  output logic        rx_last_o,
  input  logic        rx_ready_i,
  output logic [15:0] frm_len_o,
`ifdef RX_STATS_EN
  output logic [15:0] good_cnt_o,
  output logic [15:0] drop_cnt_o,
`endif
  output logic        rx_busy_o
);

  typedef enum logic [1:0] {IDLE, RECV, DROP, DRAIN} state_t;

  localparam logic [15:0] MIN_LEN16 = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);

  state_t              state_q, state_d;
  logic [7:0]          mem [MAX_LEN];
  logic [15:0]         wcnt_q, wcnt_d;
  logic [15:0]         rptr_q;
  logic [15:0]         rptr_nxt;
  logic [15:0]         rx_len;
  logic                skip_q, skip_d;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic                len_load;
  logic                good_evt;
  logic                drop_evt;

  // Length of the frame if the current MAC byte is its last one.
  assign rx_len   = wcnt_q + 16'd1;
  assign rptr_nxt = rptr_q + 16'd1;
  assign rx_busy_o = (state_q == DRAIN);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values; = is only for always_comb.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic, buffer write strobes and frame accept/drop decisions.
  always_comb begin
    // NOTE: every signal gets a default here so no branch leaves it unassigned (no inferred latch).
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    skip_d    = skip_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    len_load  = 1'b0;
    good_evt  = 1'b0;
    drop_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_mac_valid) begin
          if (skip_q) begin
            // Tail of a frame that started while the buffer was busy.
            if (rx_mac_last) begin
              skip_d   = 1'b0;
              drop_evt = 1'b1;
            end
          end else if (rx_mac_last) begin
            // One-byte frame: runt.
            drop_evt = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = '0;
            wcnt_d    = 16'd1;
            state_d   = RECV;
          end
        end
      end
      RECV: begin
        if (rx_mac_valid) begin
          if (wcnt_q >= MAX_LEN16) begin
            // Buffer already full: oversize, nothing more is written.
            drop_evt = 1'b1;
            state_d  = rx_mac_last ? IDLE : DROP;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = wcnt_q[ADDR_W-1:0];
            wcnt_d    = wcnt_q + 16'd1;
            if (rx_mac_last) begin
              if (rx_mac_err || (rx_len < MIN_LEN16)) begin
                drop_evt = 1'b1;
                state_d  = IDLE;
              end else begin
                len_load = 1'b1;
                good_evt = 1'b1;
                state_d  = DRAIN;
              end
            end
          end
        end
      end
      DROP: begin
        if (rx_mac_valid && rx_mac_last) state_d = IDLE;
      end
      DRAIN: begin
        if (rx_data_valid_o && rx_ready_i && rx_last_o) state_d = IDLE;
        // Any MAC byte while the buffer is occupied is an overrun of the new frame.
        if (rx_mac_valid) begin
          if (rx_mac_last) begin
            skip_d   = 1'b0;
            drop_evt = 1'b1;
          end else begin
            skip_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame buffer write port.
  always_ff @(posedge clk) begin
    // NOTE: the buffer has no reset; its contents are only read after being written by a frame.
    if (mem_we) mem[mem_waddr] <= rx_mac_data;
  end

  // Write counter, skip flag, length latch and replay output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q          <= '0;
      skip_q          <= 1'b0;
      rptr_q          <= '0;
      frm_len_o       <= '0;
      rx_data_o       <= 8'h00;
      rx_data_valid_o <= 1'b0;
      rx_last_o       <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      skip_q <= skip_d;
      if (len_load) begin
        frm_len_o <= rx_len;
        rptr_q    <= '0;
      end else if (state_q == DRAIN) begin
        if (!rx_data_valid_o) begin
          // First cycle in DRAIN: present byte 0.
          rx_data_valid_o <= 1'b1;
          rx_data_o       <= mem[rptr_q[ADDR_W-1:0]];
          rx_last_o       <= (rptr_q == frm_len_o - 16'd1);
        end else if (rx_ready_i) begin
          if (rx_last_o) begin
            rx_data_valid_o <= 1'b0;
            rx_last_o       <= 1'b0;
          end else begin
            rptr_q    <= rptr_nxt;
            rx_data_o <= mem[rptr_nxt[ADDR_W-1:0]];
            rx_last_o <= (rptr_nxt == frm_len_o - 16'd1);
          end
        end
      end
    end
  end

`ifdef RX_STATS_EN
  // Good and dropped frame counters, wrapping at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_cnt_o <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (good_evt) good_cnt_o <= good_cnt_o + 16'd1;
      if (drop_evt) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rx_control.sv
// tb_rx_control: randomized + directed bench for rx_control with a frame-level
// reference model and a scoreboard queue drained by an independent monitor.
module tb_rx_control;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_mac_data;
  logic        rx_mac_valid;
  logic        rx_mac_last;
  logic        rx_mac_err;
  logic [7:0]  rx_data_o;
  logic        rx_data_valid_o;
  logic        rx_last_o;
  logic        rx_ready_i;
  logic [15:0] frm_len_o;
  logic        rx_busy_o;
`ifdef RX_STATS_EN
  logic [15:0] good_cnt_o;
  logic [15:0] drop_cnt_o;
`endif

  always #5 clk = ~clk;

  rx_control #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .ADDR_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_mac_data     (rx_mac_data),
    .rx_mac_valid    (rx_mac_valid),
    .rx_mac_last     (rx_mac_last),
    .rx_mac_err      (rx_mac_err),
    .rx_data_o       (rx_data_o),
    .rx_data_valid_o (rx_data_valid_o),
    .rx_last_o       (rx_last_o),
    .rx_ready_i      (rx_ready_i),
    .frm_len_o       (frm_len_o),
`ifdef RX_STATS_EN
    .good_cnt_o      (good_cnt_o),
    .drop_cnt_o      (drop_cnt_o),
`endif
    .rx_busy_o       (rx_busy_o)
  );

  typedef struct packed {
    logic [7:0]  d;
    logic        last;
    logic [15:0] len;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass     = 0;
  int   n_total    = 0;
  int   acc_cnt    = 0;
  int   ready_mode = 0;
  int   exp_good   = 0;
  int   exp_drop   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
  endtask

  // Reference rule: a frame is replayed iff error-free and within [MIN_LEN, MAX_LEN]
  // and it did not arrive while the buffer was still being replayed.
  function automatic bit frame_ok(input int len, input bit err, input bit overrun);
    return !err && !overrun && (len >= MIN_LEN) && (len <= MAX_LEN);
  endfunction

  // Drive one frame back-to-back; returns #1 after the edge that samples its last byte.
  task automatic send_frame(input int len, input bit err, input bit overrun, input bit incr);
    logic [7:0] bytes[$];
    for (int i = 0; i < len; i++) bytes.push_back(incr ? 8'(i) : 8'($urandom));
    if (frame_ok(len, err, overrun)) begin
      exp_good++;
      for (int i = 0; i < len; i++)
        exp_q.push_back('{d: bytes[i], last: (i == len - 1), len: 16'(len)});
    end else begin
      exp_drop++;
    end
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      rx_mac_valid = 1'b1;
      rx_mac_data  = bytes[i];
      rx_mac_last  = (i == len - 1);
      rx_mac_err   = err && (i == len - 1);
    end
    @(posedge clk); #1;
    rx_mac_valid = 1'b0;
    rx_mac_last  = 1'b0;
    rx_mac_err   = 1'b0;
    rx_mac_data  = 8'h00;
  endtask

  // Bounded wait until every expected byte has been delivered and the output is idle.
  task automatic wait_idle(input string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || rx_data_valid_o) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({name, "_valid_idle"}, 32'(rx_data_valid_o), 32'd0);
`ifdef RX_STATS_EN
    check({name, "_good_cnt"}, 32'(good_cnt_o), 32'(exp_good));
    check({name, "_drop_cnt"}, 32'(drop_cnt_o), 32'(exp_drop));
`endif
    @(posedge clk); #1;
  endtask

  // Ready generator: 0 = always high, 1 = toggle each cycle, 2 = random.
  initial begin
    rx_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       rx_ready_i = 1'b1;
        1:       rx_ready_i = ~rx_ready_i;
        default: rx_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks hold-while-stalled.
  logic       hold_pend = 1'b0;
  logic [7:0] hold_d;
  logic       hold_l;
  exp_t       mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check("hold_valid", 32'(rx_data_valid_o), 32'd1);
          check("hold_data", 32'(rx_data_o), 32'(hold_d));
          check("hold_last", 32'(rx_last_o), 32'(hold_l));
        end
        if (rx_data_valid_o && rx_ready_i) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_byte: got 0x%0h with nothing expected at %0t", rx_data_o, $time);
          end else begin
            mon_e = exp_q.pop_front();
            check("data", 32'(rx_data_o), 32'(mon_e.d));
            check("last", 32'(rx_last_o), 32'(mon_e.last));
            check("frm_len", 32'(frm_len_o), 32'(mon_e.len));
            check("busy", 32'(rx_busy_o), 32'd1);
          end
        end
        hold_pend = rx_data_valid_o && !rx_ready_i;
        hold_d    = rx_data_o;
        hold_l    = rx_last_o;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int cyc;
    rst          = 1'b1;
    rx_mac_data  = 8'h00;
    rx_mac_valid = 1'b0;
    rx_mac_last  = 1'b0;
    rx_mac_err   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(rx_data_valid_o), 32'd0);
    check("rst_last", 32'(rx_last_o), 32'd0);
    check("rst_busy", 32'(rx_busy_o), 32'd0);
    check("rst_data", 32'(rx_data_o), 32'd0);
    check("rst_len", 32'(frm_len_o), 32'd0);
    rst = 1'b0;

    // Good 64-byte frame with latency check.
    ready_mode = 0;
    send_frame(64, 1'b0, 1'b0, 1'b1);
    check("lat_valid_early", 32'(rx_data_valid_o), 32'd0);
    check("lat_busy", 32'(rx_busy_o), 32'd1);
    @(posedge clk); #1;
    check("lat_valid", 32'(rx_data_valid_o), 32'd1);
    check("lat_data0", 32'(rx_data_o), 32'd0);
    check("lat_len", 32'(frm_len_o), 32'd64);
    wait_idle("good64");

    // Runt then minimum-length frame.
    send_frame(63, 1'b0, 1'b0, 1'b1);
    wait_idle("runt63");
    send_frame(64, 1'b0, 1'b0, 1'b0);
    wait_idle("after_runt");

    // One-byte runt, oversize, maximum size, errored frame.
    send_frame(1, 1'b0, 1'b0, 1'b0);
    send_frame(257, 1'b0, 1'b0, 1'b0);
    wait_idle("oversize");
    send_frame(256, 1'b0, 1'b0, 1'b0);
    wait_idle("max256");
    send_frame(100, 1'b1, 1'b0, 1'b0);
    wait_idle("err100");

    // Backpressure with ready toggling.
    ready_mode = 1;
    send_frame(80, 1'b0, 1'b0, 1'b1);
    wait_idle("backpressure");
    ready_mode = 0;
    @(posedge clk); #1;

    // Overrun: second frame starts with ~10 bytes of a 70-byte frame undrained.
    // Drain of len bytes keeps the buffer busy for edges P+1..P+len+1 after the last MAC byte.
    send_frame(70, 1'b0, 1'b0, 1'b0);
    repeat (60) @(posedge clk);
    #1;
    send_frame(64, 1'b0, (60 + 2 <= 70 + 1), 1'b0);
    wait_idle("overrun");
    send_frame(65, 1'b0, 1'b0, 1'b0);
    wait_idle("post_overrun");

    // Randomized frames under random backpressure.
    for (int n = 0; n < 12; n++) begin
      int len;
      bit err;
      case ($urandom_range(0, 3))
        0:       len = int'($urandom_range(1, 63));
        2:       len = int'($urandom_range(257, 300));
        default: len = int'($urandom_range(64, 256));
      endcase
      err = ($urandom_range(0, 4) == 0);
      ready_mode = int'($urandom_range(0, 2));
      send_frame(len, err, 1'b0, 1'b0);
      wait_idle("random");
    end
    ready_mode = 0;
    @(posedge clk); #1;

    // Reset in the middle of DRAIN after 5 accepted bytes.
    send_frame(64, 1'b0, 1'b0, 1'b0);
    base = acc_cnt;
    cyc  = 0;
    while (acc_cnt < base + 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_reached", 32'(acc_cnt >= base + 5), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    exp_good = 0;
    exp_drop = 0;
    #1;
    check("rst_mid_valid", 32'(rx_data_valid_o), 32'd0);
    check("rst_mid_last", 32'(rx_last_o), 32'd0);
    check("rst_mid_busy", 32'(rx_busy_o), 32'd0);
    check("rst_mid_len", 32'(frm_len_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send_frame(64, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("post_rst_first", 32'(rx_data_o), 32'd0);
    wait_idle("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rx_control.md
Name: rx_control

Overview:
Receive-side counterpart of the bridge's transmit controller. Accepts a byte stream from the MAC receive interface and buffers one whole frame. Rejects runt, oversize and errored frames. Replays each good frame to the bridge core over a valid/ready byte handshake, with a last-byte marker and the frame length.

Parameters:
MIN_LEN, 64, minimum accepted frame length in bytes; shorter frames are dropped.
MAX_LEN, 256, frame buffer depth and maximum accepted frame length in bytes.
ADDR_W, 8, buffer address width; must satisfy 2**ADDR_W >= MAX_LEN.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
rx_mac_data  in  8  byte from MAC receiver
rx_mac_valid  in  1  rx_mac_data valid this cycle; MAC cannot be stalled
rx_mac_last  in  1  qualifies the final byte of a frame (meaningful only with rx_mac_valid)
rx_mac_err  in  1  frame error (FCS/PHY), sampled with the last byte
rx_data_o  out  8  buffered frame byte to bridge core
rx_data_valid_o  out  1  rx_data_o valid
rx_last_o  out  1  rx_data_o is the final byte of the frame
rx_ready_i  in  1  bridge core accepts the byte when high together with rx_data_valid_o
frm_len_o  out  16  length of the frame being replayed; stable throughout DRAIN
rx_busy_o  out  1  high while in DRAIN (buffer occupied)

Behaviour:
- Interface is fixed: one clock (clk); reset is asynchronous and active-high (rst).
- Reset (asynchronous, any state) sets:
  - state to IDLE; rx_data_valid_o, rx_last_o and rx_busy_o to 0;
  - rx_data_o to 8'h00, frm_len_o to 0;
  - write count, read pointer and skip flag to 0.
  A partial frame in progress is discarded. Buffer contents are not reset.
- FSM states: IDLE, RECV, DROP, DRAIN.
- IDLE:
  - rx_mac_valid with skip flag clear: write byte to mem[0], set wcnt=1, go to RECV.
  - If rx_mac_last is also set in that cycle, the frame is 1 byte long (a runt): drop it and stay in IDLE.
- RECV: each rx_mac_valid writes mem[wcnt] and increments wcnt.
  - valid & last: len = wcnt+1. If rx_mac_err or len < MIN_LEN, drop and go to IDLE. Otherwise latch frm_len_o = len, clear the read pointer, go to DRAIN.
  - valid & !last with wcnt == MAX_LEN: oversize; go to DROP without writing.
- DROP: ignore bytes until valid & last, then go to IDLE.
- DRAIN:
  - rx_busy_o = 1.
  - rx_data_valid_o rises the cycle after DRAIN is entered, i.e. 2 cycles after the MAC last byte.
  - rx_data_o = mem[rptr]; rx_last_o = (rptr == frm_len_o-1).
  - On valid & ready: advance rptr and present the next byte in the following cycle. There are no bubbles while ready is held high, so full throughput is 1 byte/clk.
  - Outputs hold while ready is low.
  - When the last byte is accepted: go to IDLE; rx_data_valid_o and rx_last_o deassert the next cycle.
- Overrun: rx_mac_valid while in DRAIN sets the skip flag. The frame is dropped in full, even if DRAIN finishes mid-frame.
  - The skip flag clears on the valid & last that ends the skipped frame.
  - A last byte arriving the same cycle the flag would be set clears it immediately, so the frame is a single-byte drop.
- Simultaneous events: the drain's final accept and a new MAC first byte in the same cycle count as overrun, because state is still DRAIN.
- Length arithmetic is 16-bit unsigned; wcnt never exceeds MAX_LEN.

Optional Feature:
RX_STATS_EN defined:
- Adds outputs good_cnt_o[15:0] and drop_cnt_o[15:0], both reset to 0.
- good_cnt_o increments when a frame enters DRAIN.
- drop_cnt_o increments once per dropped frame, covering runt, err, oversize and overrun.
- Both counters wrap from 16'hFFFF to 0.

RX_STATS_EN undefined: the counters and their ports are absent. All other behaviour is identical.

Test Plan:
- Good frame: 64 bytes 0x00..0x3F back-to-back, last on 0x3F, ready=1. Response: 64 accepted bytes 0x00..0x3F, rx_last_o only on 0x3F, frm_len_o=64, first valid 2 cycles after MAC last.
- Runt: 63-byte frame, then a 64-byte frame. Response: only the 64-byte frame is replayed; drop_cnt_o=1, good_cnt_o=1.
- Oversize and error:
  - 257-byte frame: no output.
  - 100-byte frame with rx_mac_err=1 on last: no output.
  - drop_cnt_o=2 in total.
- Backpressure: 80-byte frame with rx_ready_i toggling 1,0,1,0. Response: every byte is delivered exactly once in order, and rx_data_o is held stable while ready=0.
- Overrun: a second frame starts while 10 bytes of a 70-byte frame remain undrained. Response: the first frame completes intact, the second produces no output, the next frame is received normally, drop_cnt_o=1.
- Reset mid-DRAIN: assert rst after 5 bytes are accepted. Response: rx_data_valid_o=0 immediately; after release, a new 64-byte frame is replayed starting at its first byte.
